serial_subtractor_ctrl: RTL and testbench

//  Bit-serial N-bit subtractor controller. Sequences one Full_Subtractor instance
//  LSB-first over WIDTH cycles to compute A - B, carrying the borrow between cycles
//  in a register. Provides a start/valid/ack handshake to the requester. Serves as
//  the low-area subtract engine for the lab datapath.

---
 rtl/serial_subtractor_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full subtractor stepped LSB-first over WIDTH
// cycles, with a start/valid/ack handshake around it.

module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);
    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] dsh_q, dsh_d, diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d, borrow_q, borrow_d, ovf_q, ovf_d;
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic             fs_diff, fs_bout;

    full_subtractor u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (brw_q),
        .diff_o (fs_diff),
        .bout_o (fs_bout)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            dsh_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dsh_q    <= dsh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        dsh_d    = dsh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    dsh_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    // Operand regs shift away, so keep the MSBs for the overflow test.
                    amsb_d  = a_i[WIDTH-1];
                    bmsb_d  = b_i[WIDTH-1];
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                dsh_d = {fs_diff, dsh_q[WIDTH-1:1]};
                brw_d = fs_bout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d  = DONE;
                    diff_d   = {fs_diff, dsh_q[WIDTH-1:1]};
                    borrow_d = fs_bout;
                    ovf_d    = (amsb_q != bmsb_q) && (fs_diff != amsb_q);
                end
            end
            DONE: begin
                if (ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q == RUN);
    assign valid_o  = (state_q == DONE);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboarded bench for serial_subtractor_ctrl at WIDTH=8 (directed + random) and
// WIDTH=16 (random), checked against a plain-arithmetic reference model.
module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] d;
        logic        b;
        logic        o;
        int          c;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int n_chk = 0;
    int n_fail = 0;

    logic        rst8, st8, ack8, rdy8, bsy8, vld8, br8, ov8;
    logic [7:0]  a8, b8, d8;
    logic        rst16, st16, ack16, rdy16, bsy16, vld16, br16, ov16;
    logic [15:0] a16, b16, d16;

    serial_subtractor_ctrl #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_n(rst8), .start_i(st8), .a_i(a8), .b_i(b8),
        .ready_o(rdy8), .busy_o(bsy8), .valid_o(vld8), .ack_i(ack8),
        .diff_o(d8), .borrow_o(br8), .ovf_o(ov8)
    );

    serial_subtractor_ctrl #(.WIDTH(16)) u16 (
        .clk_i(clk), .rst_n(rst16), .start_i(st16), .a_i(a16), .b_i(b16),
        .ready_o(rdy16), .busy_o(bsy16), .valid_o(vld16), .ack_i(ack16),
        .diff_o(d16), .borrow_o(br16), .ovf_o(ov16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: unsigned modular difference, unsigned compare, signed range test.
    function automatic exp_t model(input int w, input longint a, input longint b, input int c);
        exp_t   e;
        longint half, full, sa, sb, dd;
        half = longint'(1) << (w - 1);
        full = half * 2;
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        dd   = sa - sb;
        e.d  = 32'((a - b + full) % full);
        e.b  = (a < b);
        e.o  = (dd >= half) || (dd < -half);
        e.c  = c;
        return e;
    endfunction

    logic pv8 = 1'b0, pv16 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk("onehot8", 32'($countones({rdy8, bsy8, vld8})), 32'd1);
        if (vld8 && !pv8) begin
            if (q8.size() == 0) chk("unexpected_valid8", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                chk("diff8", 32'(d8), e.d);
                chk("borrow8", 32'(br8), 32'(e.b));
                chk("ovf8", 32'(ov8), 32'(e.o));
                chk("latency8", 32'(cyc), 32'(e.c));
            end
        end
        pv8 = vld8;
    end

    always @(negedge clk) begin
        exp_t e;
        chk("onehot16", 32'($countones({rdy16, bsy16, vld16})), 32'd1);
        if (vld16 && !pv16) begin
            if (q16.size() == 0) chk("unexpected_valid16", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                chk("diff16", 32'(d16), e.d);
                chk("borrow16", 32'(br16), 32'(e.b));
                chk("ovf16", 32'(ov16), 32'(e.o));
                chk("latency16", 32'(cyc), 32'(e.c));
            end
        end
        pv16 = vld16;
    end

    // pulse>0: re-assert start (with other operands) so it lands on edge T0+pulse.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int pulse,
                       input int hold, input bit ack_start);
        int   k, bc;
        exp_t e;
        k = 0;
        while (!rdy8 && k < 40) begin @(negedge clk); k++; end
        chk("ready8", 32'(rdy8), 32'd1);
        st8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        st8 = 1'b0;
        e = model(8, longint'(a), longint'(b), cyc + 8);
        q8.push_back(e);
        a8 = 8'($urandom); b8 = 8'($urandom);
        k = 0; bc = 0;
        forever begin
            @(negedge clk);
            if (vld8 || k > 20) break;
            if (bsy8) bc++;
            if (pulse != 0 && k == pulse - 1) begin st8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
            else st8 = 1'b0;
            k++;
        end
        st8 = 1'b0;
        chk("valid8_seen", 32'(vld8), 32'd1);
        chk("busy8_cycles", 32'(bc), 32'd8);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid8", 32'(vld8), 32'd1);
            chk("hold_diff8", 32'(d8), e.d);
        end
        ack8 = 1'b1; st8 = ack_start;
        @(posedge clk); #1;
        ack8 = 1'b0; st8 = 1'b0;
        if (ack_start) chk("start_in_done_ignored8", 32'(rdy8), 32'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int k;
        k = 0;
        while (!rdy16 && k < 40) begin @(negedge clk); k++; end
        chk("ready16", 32'(rdy16), 32'd1);
        st16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk); #1;
        st16 = 1'b0;
        q16.push_back(model(16, longint'(a), longint'(b), cyc + 16));
        a16 = 16'($urandom); b16 = 16'($urandom);
        k = 0;
        while (!vld16 && k < 40) begin @(negedge clk); k++; end
        chk("valid16_seen", 32'(vld16), 32'd1);
        ack16 = 1'b1;
        @(posedge clk); #1;
        ack16 = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst8 = 1'b0; st8 = 1'b0; ack8 = 1'b0; a8 = '0; b8 = '0;
        rst16 = 1'b0; st16 = 1'b0; ack16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready8", 32'(rdy8), 32'd1);
        chk("rst_busy8", 32'(bsy8), 32'd0);
        chk("rst_valid8", 32'(vld8), 32'd0);
        chk("rst_diff8", 32'(d8), 32'd0);
        chk("rst_flags8", 32'({br8, ov8}), 32'd0);
        chk("rst_ready16", 32'(rdy16), 32'd1);
        rst8 = 1'b1; rst16 = 1'b1;
        @(negedge clk);
        fork
            begin
                op8(8'h5A, 8'h3C, 0, 0, 1'b0);
                op8(8'h33, 8'h11, 3, 0, 1'b0);
                op8(8'h00, 8'h01, 0, 1, 1'b0);
                op8(8'h80, 8'h01, 0, 0, 1'b0);
                // Asynchronous reset in the middle of RUN
                st8 = 1'b1; a8 = 8'h55; b8 = 8'h0F;
                @(posedge clk); #1;
                st8 = 1'b0;
                repeat (3) @(posedge clk);
                #2 rst8 = 1'b0;
                #1;
                chk("midrun_rst_ready8", 32'(rdy8), 32'd1);
                chk("midrun_rst_busy8", 32'(bsy8), 32'd0);
                chk("midrun_rst_valid8", 32'(vld8), 32'd0);
                chk("midrun_rst_diff8", 32'(d8), 32'd0);
                chk("midrun_rst_borrow8", 32'(br8), 32'd0);
                chk("midrun_rst_ovf8", 32'(ov8), 32'd0);
                repeat (2) @(negedge clk);
                rst8 = 1'b1;
                op8(8'h10, 8'h20, 0, 0, 1'b0);
                op8(8'hC3, 8'h5A, 0, 5, 1'b1);
                op8(8'h42, 8'h42, 0, 0, 1'b0);
                op8(8'h00, 8'h00, 0, 0, 1'b0);
                op8(8'hFF, 8'hFF, 0, 0, 1'b0);
                op8(8'hFF, 8'h00, 0, 0, 1'b0);
                op8(8'h00, 8'hFF, 0, 0, 1'b0);
                op8(8'h7F, 8'h80, 0, 0, 1'b0);
                for (int i = 0; i < 1000; i++)
                    op8(8'($urandom), 8'($urandom), 0, int'($urandom_range(0, 2)),
                        ($urandom_range(0, 3) == 0));
            end
            begin
                op16(16'hFFFF, 16'h0000);
                op16(16'h8000, 16'h0001);
                op16(16'h0000, 16'hFFFF);
                op16(16'h1234, 16'h1234);
                for (int i = 0; i < 1000; i++)
                    op16(16'($urandom), 16'($urandom));
            end
        join
        repeat (3) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
